// File: rtl/fixed_point_alu_pipe.sv
// Pipelined saturating fixed-point ALU: operand stage S1, output stage S2,
// plus a one-bit-per-cycle restoring divider that holds S1 while it runs.
module fixed_point_alu_pipe #(
    parameter int WIDTH = 32,
    parameter int FRAC  = 16,
    parameter int TAG_W = 4
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             valid_in,
    output logic             ready_out,
    input  logic [WIDTH-1:0] d0_in,
    input  logic [WIDTH-1:0] d1_in,
    input  logic [2:0]       sel_in,
    input  logic [TAG_W-1:0] tag_in,
    output logic             valid_out,
    input  logic             ready_in,
    output logic [WIDTH-1:0] res_out,
    output logic             gt_out,
    output logic             eq_out,
    output logic             lt_out,
    output logic             sat_out,
    output logic             div_zero_out,
    output logic [TAG_W-1:0] tag_out
);
    localparam int N  = WIDTH + FRAC;
    localparam int CW = $clog2(N);
    localparam logic [WIDTH-1:0] MAXV    = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MINV    = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1) << FRAC;
    localparam logic [WIDTH-1:0] NEG_ONE = ~ONE + WIDTH'(1);
    localparam logic [2:0] OP_ADD = 3'b000, OP_MUL = 3'b001, OP_DIV = 3'b010, OP_MAX = 3'b011,
                           OP_SUB = 3'b100, OP_SGN = 3'b101, OP_MIN = 3'b110, OP_ABS = 3'b111;

    typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

    state_t             state_q;
    logic               s1_vld_q;
    logic [WIDTH-1:0]   s1_d0_q, s1_d1_q;
    logic [2:0]         s1_sel_q;
    logic [TAG_W-1:0]   s1_tag_q;
    logic [WIDTH-1:0]   rem_q, dvs_q;
    logic [N-1:0]       quo_q;
    logic [CW-1:0]      cnt_q;
    logic               vld_q, gt_q, eq_q, lt_q, sat_q, dz_q;
    logic [WIDTH-1:0]   res_q;
    logic [TAG_W-1:0]   tag_q;

    logic signed [WIDTH-1:0] a, b;
    assign a = s1_d1_q;
    assign b = s1_d0_q;

    logic div_nz, s2_free, fast_adv, div_fin, accept;
    assign div_nz    = s1_vld_q && (s1_sel_q == OP_DIV) && (s1_d0_q != '0);
    assign s2_free   = !vld_q || ready_in;
    assign fast_adv  = s1_vld_q && !div_nz && s2_free && (state_q == IDLE);
    assign div_fin   = (state_q == DONE) && s2_free;
    // A divide sitting in S1 must not be overwritten while it launches.
    assign ready_out = !rst_in && (state_q == IDLE) && (!s1_vld_q || fast_adv);
    assign accept    = valid_in && ready_out;

    logic [WIDTH:0]              sum_w, dif_w;
    logic [2*WIDTH-1:0]          prod;
    logic signed [2*WIDTH-1:0]   psh;
    logic [WIDTH-1:0]            mag0, mag1;
    assign sum_w = {a[WIDTH-1], a} + {b[WIDTH-1], b};
    assign dif_w = {a[WIDTH-1], a} - {b[WIDTH-1], b};
    assign prod  = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
    assign psh   = $signed(prod) >>> FRAC;
    assign mag1  = s1_d1_q[WIDTH-1] ? '0 - s1_d1_q : s1_d1_q;
    assign mag0  = s1_d0_q[WIDTH-1] ? '0 - s1_d0_q : s1_d0_q;

    logic [WIDTH-1:0] fast_res;
    logic             fast_sat, fast_dz;
    always_comb begin
        fast_res = '0;
        fast_sat = 1'b0;
        fast_dz  = 1'b0;
        case (s1_sel_q)
            OP_ADD: begin
                fast_res = sum_w[WIDTH-1:0];
                if (sum_w[WIDTH] != sum_w[WIDTH-1]) begin
                    fast_sat = 1'b1;
                    fast_res = sum_w[WIDTH] ? MINV : MAXV;
                end
            end
            OP_SUB: begin
                fast_res = dif_w[WIDTH-1:0];
                if (dif_w[WIDTH] != dif_w[WIDTH-1]) begin
                    fast_sat = 1'b1;
                    fast_res = dif_w[WIDTH] ? MINV : MAXV;
                end
            end
            OP_MUL: begin
                fast_res = psh[WIDTH-1:0];
                if (psh[2*WIDTH-1:WIDTH-1] != {(WIDTH+1){psh[2*WIDTH-1]}}) begin
                    fast_sat = 1'b1;
                    fast_res = psh[2*WIDTH-1] ? MINV : MAXV;
                end
            end
            OP_DIV: begin
                // Only divide-by-zero takes this path; nonzero divisors use the divider.
                fast_dz = 1'b1;
                if (s1_d1_q[WIDTH-1]) begin
                    fast_res = MINV;
                    fast_sat = 1'b1;
                end else if (|s1_d1_q) begin
                    fast_res = MAXV;
                    fast_sat = 1'b1;
                end
            end
            OP_MAX: fast_res = (a > b) ? s1_d1_q : s1_d0_q;
            OP_MIN: fast_res = (a < b) ? s1_d1_q : s1_d0_q;
            OP_SGN: fast_res = s1_d1_q[WIDTH-1] ? NEG_ONE : ((|s1_d1_q) ? ONE : '0);
            OP_ABS: begin
                fast_res = mag1;
                if (s1_d1_q == MINV) begin
                    fast_res = MAXV;
                    fast_sat = 1'b1;
                end
            end
            default: ;
        endcase
    end

    logic [WIDTH:0]   rem_sh, diff;
    logic             ge;
    logic [WIDTH-1:0] rem_d;
    logic [N-1:0]     quo_d;
    assign rem_sh = {rem_q, quo_q[N-1]};
    assign diff   = rem_sh - {1'b0, dvs_q};
    assign ge     = !diff[WIDTH];
    assign rem_d  = ge ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    assign quo_d  = {quo_q[N-2:0], ge};

    logic             neg;
    logic [WIDTH-1:0] div_res;
    logic             div_sat;
    assign neg = a[WIDTH-1] ^ b[WIDTH-1];
    always_comb begin
        div_res = neg ? '0 - quo_q[WIDTH-1:0] : quo_q[WIDTH-1:0];
        div_sat = 1'b0;
        if (!neg && quo_q > {{FRAC{1'b0}}, MAXV}) begin
            div_res = MAXV;
            div_sat = 1'b1;
        end else if (neg && quo_q > {{FRAC{1'b0}}, MINV}) begin
            div_res = MINV;
            div_sat = 1'b1;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            rem_q   <= '0;
            dvs_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: if (div_nz) begin
                    state_q <= DIV;
                    rem_q   <= '0;
                    dvs_q   <= mag0;
                    quo_q   <= {mag1, {FRAC{1'b0}}};
                    cnt_q   <= '0;
                end
                DIV: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(N-1)) state_q <= DONE;
                end
                DONE: if (s2_free) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            s1_vld_q <= 1'b0;
            s1_d0_q  <= '0;
            s1_d1_q  <= '0;
            s1_sel_q <= '0;
            s1_tag_q <= '0;
        end else if (accept) begin
            s1_vld_q <= 1'b1;
            s1_d0_q  <= d0_in;
            s1_d1_q  <= d1_in;
            s1_sel_q <= sel_in;
            s1_tag_q <= tag_in;
        end else if (fast_adv || div_fin) begin
            s1_vld_q <= 1'b0;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            vld_q <= 1'b0;
            res_q <= '0;
            gt_q  <= 1'b0;
            eq_q  <= 1'b0;
            lt_q  <= 1'b0;
            sat_q <= 1'b0;
            dz_q  <= 1'b0;
            tag_q <= '0;
        end else if (s2_free) begin
            vld_q <= fast_adv || div_fin;
            if (fast_adv || div_fin) begin
                res_q <= div_fin ? div_res : fast_res;
                sat_q <= div_fin ? div_sat : fast_sat;
                dz_q  <= div_fin ? 1'b0 : fast_dz;
                gt_q  <= a > b;
                eq_q  <= a == b;
                lt_q  <= a < b;
                tag_q <= s1_tag_q;
            end
        end
    end

    assign valid_out    = vld_q;
    assign res_out      = res_q;
    assign gt_out       = gt_q;
    assign eq_out       = eq_q;
    assign lt_out       = lt_q;
    assign sat_out      = sat_q;
    assign div_zero_out = dz_q;
    assign tag_out      = tag_q;
endmodule
